// File: rtl/pfb_output_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pfb_output_scheduler
// Purpose  : Frame-level round-robin share of the PFB output AXI-Stream writer
//            between NUM_CH channel sources, with TLAST/ID generation and a
//            stall watchdog.
// Revision : 1.0
// ============================================================================
module pfb_output_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 256,
  parameter int TIMEOUT   = 1024,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [CH_W-1:0]          m_tuser,
  output logic                     busy,
  output logic                     stall_flag,
  input  logic                     stall_clear
);

  localparam int BEAT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BEAT_W-1:0]  C_LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [STALL_W-1:0] C_STALL_MAX = STALL_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_grant;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic                r_stall_flag;

  logic                w_xfer;
  logic                w_found;
  logic [CH_W-1:0]     w_next_grant;
  logic [DATA_W-1:0]   w_tdata;
  logic                w_tvalid;
  logic [NUM_CH-1:0]   w_tready;
  logic                w_last;
  logic                w_hs;
  logic                w_stall_set;

  assign w_xfer = (r_state == ST_XFER);

  // Scan from farthest to nearest so the channel right after the last grant
  // is the one left standing; the last-served channel ends up lowest priority.
  always_comb begin
    int idx;
    idx          = 0;
    w_found      = 1'b0;
    w_next_grant = r_grant;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(r_grant) + i) % NUM_CH;
      if (s_tvalid[idx]) begin
        w_found      = 1'b1;
        w_next_grant = CH_W'(idx);
      end
    end
  end

  always_comb begin
    w_tdata  = '0;
    w_tvalid = 1'b0;
    w_tready = '0;
    if (w_xfer) begin
      w_tdata           = s_tdata[int'(r_grant)*DATA_W +: DATA_W];
      w_tvalid          = s_tvalid[r_grant];
      w_tready[r_grant] = m_tready;
    end
  end

  assign w_last      = w_xfer && (r_beat_cnt == C_LAST_BEAT);
  assign w_hs        = w_tvalid && m_tready;
  assign w_stall_set = w_xfer && !w_hs && (r_stall_cnt == C_STALL_MAX);

  assign m_tdata    = w_tdata;
  assign m_tvalid   = w_tvalid;
  assign s_tready   = w_tready;
  assign m_tlast    = w_last;
  assign m_tuser    = w_xfer ? r_grant : '0;
  assign busy       = w_xfer;
  assign stall_flag = r_stall_flag;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_ARB;
      r_grant      <= CH_W'(NUM_CH - 1);
      r_beat_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_stall_flag <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          r_stall_cnt <= '0;
          if (enable && w_found) begin
            r_grant <= w_next_grant;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_hs) begin
            r_stall_cnt <= '0;
            if (w_last) begin
              r_beat_cnt <= '0;
              r_state    <= ST_ARB;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (r_stall_cnt != C_STALL_MAX) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
        end
        default: r_state <= ST_ARB;
      endcase

      // A fresh stall outranks a simultaneous clear so no event is lost.
      if (w_stall_set) begin
        r_stall_flag <= 1'b1;
      end else if (stall_clear) begin
        r_stall_flag <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pfb_output_scheduler.sv
`default_nettype none
// Table-driven bench for pfb_output_scheduler: NUM_CH=4, FRAME_LEN=4, TIMEOUT=8.
module tb_pfb_output_scheduler;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     enable;
  logic [NUM_CH*DATA_W-1:0] s_tdata;
  logic [NUM_CH-1:0]        s_tvalid;
  logic [NUM_CH-1:0]        s_tready;
  logic [DATA_W-1:0]        m_tdata;
  logic                     m_tvalid;
  logic                     m_tready;
  logic                     m_tlast;
  logic [1:0]               m_tuser;
  logic                     busy;
  logic                     stall_flag;
  logic                     stall_clear;

  pfb_output_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(4), .TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .busy(busy),
    .stall_flag(stall_flag), .stall_clear(stall_clear)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [3:0] vld;
    logic       rdy;
    logic       clr;
    logic       mv;
    logic       ml;
    logic [1:0] mu;
    logic       bsy;
    logic [3:0] str;
    logic       sf;
  } vec_t;

  vec_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic vec(input logic rst, input logic en, input logic [3:0] vld,
                     input logic rdy, input logic clr, input logic mv,
                     input logic ml, input logic [1:0] mu, input logic bsy,
                     input logic [3:0] str, input logic sf);
    q.push_back('{rst, en, vld, rdy, clr, mv, ml, mu, bsy, str, sf});
  endtask

  // One ARB cycle: every output is idle.
  task automatic arb(input logic en, input logic [3:0] vld);
    vec(1'b0, en, vld, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
  endtask

  // A full 4-beat frame with m_tready held high.
  task automatic frame(input int ch, input logic [3:0] vld);
    for (int b = 0; b < 4; b++)
      vec(1'b0, 1'b1, vld, 1'b1, 1'b0, 1'b1, (b == 3), 2'(ch), 1'b1,
          4'(1 << ch), 1'b0);
  endtask

  task automatic xfer3(input logic rdy, input logic clr, input logic ml,
                       input logic sf);
    vec(1'b0, 1'b1, 4'b1000, rdy, clr, 1'b1, ml, 2'd3, 1'b1,
        rdy ? 4'b1000 : 4'b0000, sf);
  endtask

  initial begin
    vec_t        v;
    logic [9:0]  act, exp;
    logic [31:0] exp_d;

    // Reset state, then basic frame on ch2 (only ch2 valid) and re-grant.
    arb(1'b0, 4'b1111);
    arb(1'b1, 4'b0100);
    frame(2, 4'b0100);
    arb(1'b1, 4'b0100);
    // Round robin with all valid: 2 (continuing), 3, 0.
    frame(2, 4'b1111);
    arb(1'b1, 4'b1111);
    frame(3, 4'b1111);
    arb(1'b1, 4'b1111);
    frame(0, 4'b1111);
    // Backpressure and a ch1 source gap; ch0/ch3 stay valid but unserved.
    arb(1'b1, 4'b1011);
    vec(0, 1, 4'b1011, 1, 0, 1, 0, 2'd1, 1, 4'b0010, 0);
    vec(0, 1, 4'b1011, 0, 0, 1, 0, 2'd1, 1, 4'b0000, 0);
    vec(0, 1, 4'b1011, 1, 0, 1, 0, 2'd1, 1, 4'b0010, 0);
    vec(0, 1, 4'b1001, 0, 0, 0, 0, 2'd1, 1, 4'b0000, 0);
    vec(0, 1, 4'b1001, 1, 0, 0, 0, 2'd1, 1, 4'b0010, 0);
    vec(0, 1, 4'b1001, 0, 0, 0, 0, 2'd1, 1, 4'b0000, 0);
    vec(0, 1, 4'b1011, 1, 0, 1, 0, 2'd1, 1, 4'b0010, 0);
    vec(0, 1, 4'b1011, 0, 0, 1, 1, 2'd1, 1, 4'b0000, 0);
    vec(0, 1, 4'b1011, 1, 0, 1, 1, 2'd1, 1, 4'b0010, 0);
    // Enable dropped after beat 2 of a ch0 frame.
    arb(1'b1, 4'b0001);
    vec(0, 1, 4'b0001, 1, 0, 1, 0, 2'd0, 1, 4'b0001, 0);
    vec(0, 1, 4'b0001, 1, 0, 1, 0, 2'd0, 1, 4'b0001, 0);
    vec(0, 0, 4'b0001, 1, 0, 1, 0, 2'd0, 1, 4'b0001, 0);
    vec(0, 0, 4'b0001, 1, 0, 1, 1, 2'd0, 1, 4'b0001, 0);
    arb(1'b0, 4'b1111);
    arb(1'b0, 4'b1111);
    arb(1'b0, 4'b1111);
    arb(1'b1, 4'b1000);
    // Watchdog on a ch3 frame held off by m_tready=0.
    for (int c = 0; c < 8; c++) xfer3(1'b0, 1'b0, 1'b0, 1'b0);
    xfer3(1'b0, 1'b0, 1'b0, 1'b1);
    xfer3(1'b0, 1'b0, 1'b0, 1'b1);
    xfer3(1'b0, 1'b1, 1'b0, 1'b1);   // clear loses to a simultaneous set
    xfer3(1'b0, 1'b0, 1'b0, 1'b1);
    xfer3(1'b1, 1'b1, 1'b0, 1'b1);   // handshake + clear
    for (int c = 0; c < 7; c++) xfer3(1'b0, 1'b0, 1'b0, 1'b0);
    xfer3(1'b1, 1'b0, 1'b0, 1'b0);
    xfer3(1'b1, 1'b1, 1'b0, 1'b0);
    xfer3(1'b1, 1'b0, 1'b1, 1'b0);
    // Reset at beat 2 of a ch3 frame; next grant must be ch0 with a full frame.
    arb(1'b1, 4'b1000);
    vec(0, 1, 4'b1000, 1, 0, 1, 0, 2'd3, 1, 4'b1000, 0);
    vec(0, 1, 4'b1000, 1, 0, 1, 0, 2'd3, 1, 4'b1000, 0);
    vec(1, 1, 4'b1000, 1, 0, 1, 0, 2'd3, 1, 4'b1000, 0);
    arb(1'b1, 4'b1111);
    frame(0, 4'b1111);
    arb(1'b1, 4'b1111);
    frame(1, 4'b1111);

    reset       = 1'b1;
    enable      = 1'b0;
    s_tvalid    = '0;
    s_tdata     = '0;
    m_tready    = 1'b0;
    stall_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    for (int i = 0; i < q.size(); i++) begin
      v           = q[i];
      reset       = v.rst;
      enable      = v.en;
      s_tvalid    = v.vld;
      m_tready    = v.rdy;
      stall_clear = v.clr;
      for (int k = 0; k < NUM_CH; k++)
        s_tdata[k*DATA_W +: DATA_W] = {8'hA0 + 8'(k), 24'(i)};
      @(negedge clock);

      act = {m_tvalid, m_tlast, m_tuser, busy, s_tready, stall_flag};
      exp = {v.mv, v.ml, v.mu, v.bsy, v.str, v.sf};
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL ctrl vec %0d: got {mv,ml,mu,busy,str,sf}=%b want %b",
                    i, act, exp);

      if (v.bsy) begin
        exp_d = {8'hA0 + 8'(v.mu), 24'(i)};
        n_total++;
        if (m_tdata === exp_d) n_pass++;
        else $display("FAIL data vec %0d: got m_tdata=%h want %h", i, m_tdata, exp_d);
      end

      @(posedge clock);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pfb_output_scheduler.md
Name: pfb_output_scheduler

Overview:
- Frame-level round-robin scheduler sharing the single PFB output AXI-Stream writer between NUM_CH per-channel frame sources.
- Grants one channel per frame of FRAME_LEN beats, passes that channel's stream through, and generates TLAST and the channel ID.
- Includes a stall watchdog that flags a stuck output frame to the deadlock-monitor infrastructure.

Parameters:
- NUM_CH, 4, number of channel sources; at least 2.
- DATA_W, 32, sample word width.
- FRAME_LEN, 256, beats per frame; at least 2.
- TIMEOUT, 1024, consecutive no-handshake cycles in XFER before stall_flag sets.
- CH_W, derived as max(1, clog2(NUM_CH)); not user-set.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allow new frame grants.
- s_tdata  in  NUM_CH*DATA_W  channel data; channel k is in bits [k*DATA_W +: DATA_W].
- s_tvalid  in  NUM_CH  per-channel valid.
- s_tready  out  NUM_CH  per-channel ready.
- m_tdata  out  DATA_W  output data.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  last beat of a frame.
- m_tuser  out  CH_W  granted channel ID.
- busy  out  1  high while in XFER.
- stall_flag  out  1  sticky watchdog flag.
- stall_clear  in  1  clears stall_flag.

Behaviour:
- Clock and reset: clock is clock; reset is reset, synchronous, active-high.
- Reset values: state=ARB, grant=NUM_CH-1 (so channel 0 wins first), beat_cnt=0, stall_cnt=0, stall_flag=0. All outputs are 0, including s_tready, m_tvalid, m_tlast, m_tuser and busy.
- State ARB:
  - if enable=1 and any s_tvalid is high, select the first k with s_tvalid[k]=1, searching grant+1, grant+2, ... modulo NUM_CH.
  - register grant=k and go to XFER the next cycle.
  - otherwise stay in ARB.
  - outputs in ARB: m_tvalid=0 and all s_tready=0.
- State XFER, combinational pass-through of granted channel g:
  - m_tdata = s_tdata[g], m_tvalid = s_tvalid[g], s_tready[g] = m_tready.
  - all other s_tready are 0.
  - m_tuser = g, busy = 1.
  - m_tlast = (beat_cnt == FRAME_LEN-1).
- Handshake: a beat transfers when m_tvalid & m_tready.
  - on a handshake, beat_cnt increments.
  - on the handshake with m_tlast, beat_cnt goes to 0 and state goes to ARB.
  - this gives exactly one bubble cycle between frames.
- Frame atomicity:
  - a grant is never revoked mid-frame.
  - deasserting enable mid-frame finishes the current frame, then the block idles in ARB.
  - the granted channel dropping tvalid mid-frame holds the grant; no other channel is served.
- Fairness: after serving channel g, channel g has the lowest priority in the next arbitration. If only one channel is valid, it may be granted back-to-back.
- Watchdog:
  - in XFER, stall_cnt increments each cycle without a handshake.
  - stall_cnt resets to 0 on any handshake or on leaving XFER.
  - when stall_cnt reaches TIMEOUT-1 and the current cycle also has no handshake, stall_flag sets to 1.
  - stall_flag stays set until stall_clear=1 or reset.
  - if stall_clear and the set condition occur in the same cycle, set wins.
  - stall_cnt saturates at TIMEOUT-1; the flag does not affect data flow.
- Reset mid-frame: the frame is abandoned, there is no TLAST, and the next grant starts at channel 0.
- Arithmetic: beat_cnt is clog2(FRAME_LEN) bits; stall_cnt is clog2(TIMEOUT) bits. Neither wraps other than as stated above.
- Latency: first output beat appears 1 cycle after entering ARB with a valid request (the ARB cycle itself). Data path is combinational, with no added latency.

Test Plan:
- Basic frame: reset; enable=1; only ch2 valid; m_tready=1; FRAME_LEN=4.
  - required: 4 beats with m_tuser=2 and m_tlast on beat 4.
  - then 1 bubble, then ch2 granted again.
- Round robin: all 4 channels always valid; m_tready=1.
  - required: grants in order 0,1,2,3,0,... each of 4 beats; s_tready is never high on an ungranted channel.
- Backpressure and source gaps: ch1 frame; m_tready toggles 1,0,1,0; ch1 tvalid drops for 3 cycles mid-frame.
  - required: exactly 4 handshakes, data order preserved, m_tlast only on the 4th handshake.
  - ch0 and ch3 stay ungranted while valid.
- Enable drop: enable=0 after beat 2 of a ch0 frame.
  - required: frame completes with m_tlast; busy then goes 0; no further grant until enable=1.
- Watchdog: TIMEOUT=8; in XFER hold m_tready=0.
  - required: stall_flag rises after the 8th stall cycle and stays set.
  - stall_clear pulse clears it; the next handshake resets stall_cnt.
- Reset mid-frame: assert reset at beat 2 of a ch3 frame.
  - required: all outputs 0 the next cycle; after release with all channels valid, the first grant is ch0.
